iter_alu: RTL

- Parametrised, clocked successor to the CPU's combinational ALU: same base opcode map, generalised to WIDTH bits, plus iterative unsigned multiply, divide and remainder.
- Operands are accepted over a valid/ready handshake and the result is held until the consumer takes it.
- Sits in EX; the control unit stalls the pipeline while in_ready or out_valid gates progress.

---
 rtl/iter_alu.sv | 186 ++++++++++++++++++
 1 files changed

// File: rtl/iter_alu.sv
// Clocked ALU with valid/ready handshake: single-cycle logic/arith ops plus
// iterative shift-add multiply and restoring divide/remainder over WIDTH steps.
module iter_alu #(
    parameter int WIDTH = 32,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [3:0]       ALU_Control,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] ALU_Result,
    output logic             zero,
    output logic             div_by_zero
);

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        DONE
    } state_t;

    typedef enum logic [3:0] {
        OP_AND   = 4'b0000,
        OP_OR    = 4'b0001,
        OP_XOR   = 4'b0010,
        OP_SRA   = 4'b0011,
        OP_SLL   = 4'b0100,
        OP_SUB   = 4'b0101,
        OP_ADD   = 4'b0110,
        OP_SLTU  = 4'b0111,
        OP_EQ    = 4'b1000,
        OP_LTU   = 4'b1001,
        OP_RSV0  = 4'b1010,
        OP_RSV1  = 4'b1011,
        OP_PASSB = 4'b1100,
        OP_MUL   = 4'b1101,
        OP_DIVU  = 4'b1110,
        OP_REMU  = 4'b1111
    } op_t;

    state_t           state;
    state_t           state_next;
    op_t              op_in;
    op_t              op_r;
    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] opa;
    logic [WIDTH-1:0] opb;
    logic [SHW-1:0]   cnt;
    logic             fire;
    logic             is_iter;
    logic             is_div;
    logic             last_step;
    logic [WIDTH-1:0] sc_result;
    logic             sc_zero;
    logic [WIDTH-1:0] step_acc;
    logic [WIDTH-1:0] step_opa;
    logic [WIDTH-1:0] step_opb;
    logic [WIDTH:0]   rem_shift;
    logic [WIDTH:0]   rem_diff;
    logic [WIDTH-1:0] iter_result;

    assign op_in     = op_t'(ALU_Control);
    assign fire      = in_valid && in_ready;
    assign is_iter   = op_in inside {OP_MUL, OP_DIVU, OP_REMU};
    assign is_div    = op_in inside {OP_DIVU, OP_REMU};
    assign last_step = (cnt == SHW'(WIDTH - 1));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    state_next = is_iter ? CALC : DONE;
                end
            end
            CALC: begin
                if (last_step) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        sc_result = '0;
        case (op_in)
            OP_AND:   sc_result = A & B;
            OP_OR:    sc_result = A | B;
            OP_XOR:   sc_result = A ^ B;
            OP_SRA:   sc_result = $signed(A) >>> B[SHW-1:0];
            OP_SLL:   sc_result = A << B[SHW-1:0];
            OP_SUB:   sc_result = A - B;
            OP_ADD:   sc_result = A + B;
            OP_SLTU:  sc_result = {{(WIDTH-1){1'b0}}, (A < B)};
            OP_PASSB: sc_result = B;
            default:  sc_result = '0;
        endcase
        sc_zero = (sc_result == '0);
        if (op_in == OP_EQ) begin
            sc_zero = (A == B);
        end else if (op_in == OP_LTU) begin
            sc_zero = (A < B);
        end
    end

    // MUL: acc=product, opa=multiplicand, opb=multiplier.
    // DIVU/REMU: acc=partial remainder, opa=dividend shifting out / quotient shifting in, opb=divisor.
    // A zero divisor never borrows, so the quotient fills with ones and the remainder rebuilds A.
    always_comb begin
        rem_shift = {acc, opa[WIDTH-1]};
        rem_diff  = rem_shift - {1'b0, opb};
        step_acc  = acc;
        step_opa  = opa;
        step_opb  = opb;
        if (op_r == OP_MUL) begin
            step_acc = opb[0] ? (acc + opa) : acc;
            step_opa = opa << 1;
            step_opb = opb >> 1;
        end else if (!rem_diff[WIDTH]) begin
            step_acc = rem_diff[WIDTH-1:0];
            step_opa = {opa[WIDTH-2:0], 1'b1};
        end else begin
            step_acc = rem_shift[WIDTH-1:0];
            step_opa = {opa[WIDTH-2:0], 1'b0};
        end
        iter_result = (op_r == OP_DIVU) ? step_opa : step_acc;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            op_r        <= OP_AND;
            acc         <= '0;
            opa         <= '0;
            opb         <= '0;
            cnt         <= '0;
            ALU_Result  <= '0;
            zero        <= 1'b0;
            div_by_zero <= 1'b0;
        end else if (fire) begin
            op_r        <= op_in;
            cnt         <= '0;
            div_by_zero <= is_div && (B == '0);
            if (is_iter) begin
                acc <= '0;
                opa <= A;
                opb <= B;
            end else begin
                ALU_Result <= sc_result;
                zero       <= sc_zero;
            end
        end else if (state == CALC) begin
            acc <= step_acc;
            opa <= step_opa;
            opb <= step_opb;
            cnt <= cnt + SHW'(1);
            if (last_step) begin
                ALU_Result <= iter_result;
                zero       <= (iter_result == '0);
            end
        end
    end

endmodule
